// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin subtractor with start/busy/done handshake
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             br;
`ifdef SERIAL_SUB_OVF_EN
  logic             msb_a;
  logic             msb_b;
`endif

  // Single full-subtractor cell fed by the operand LSBs.
  logic x, y, d, br_next;
  assign x       = sh_a[0];
  assign y       = sh_b[0];
  assign d       = x ^ y ^ br;
  assign br_next = (~x & y) | (~x & br) | (y & br);

  // The minuend register doubles as the result register: each difference bit
  // enters at the MSB as the consumed minuend bit leaves at the LSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_a <= 1'b0;
      msb_b <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
`ifdef SERIAL_SUB_OVF_EN
            msb_a <= a[WIDTH-1];
            msb_b <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          sh_a <= {d, sh_a[WIDTH-1:1]};
          sh_b <= {1'b0, sh_b[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= {d, sh_a[WIDTH-1:1]};
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (msb_a ^ msb_b) & (d ^ msb_a);
`endif
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
// Covers SERIAL_SUB_OVF_EN checks when that macro is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Transaction-level reference: accept, wait WIDTH cycles, publish a - b - bin.
  int           m_phase;
  int           m_cyc;
  logic [W-1:0] ca, cb;
  logic         cbin;
  logic [W:0]   r;
  logic         e_busy, e_done, e_bout, e_ovf;
  logic [W-1:0] e_diff;
  bit           check_en = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_cyc = 0;
      e_busy = 0; e_done = 0; e_diff = '0; e_bout = 0; e_ovf = 0;
    end else begin
      case (m_phase)
        0: begin
          e_done = 0;
          if (start) begin
            ca = a; cb = b; cbin = bin;
            m_cyc = 0; m_phase = 1; e_busy = 1;
          end
        end
        1: begin
          m_cyc++;
          if (m_cyc == W) begin
            r      = {1'b0, ca} - {1'b0, cb} - {{W{1'b0}}, cbin};
            e_diff = r[W-1:0];
            e_bout = r[W];
            e_ovf  = (ca[W-1] ^ cb[W-1]) & (e_diff[W-1] ^ ca[W-1]);
            e_busy = 0; e_done = 1; m_phase = 2;
          end
        end
        default: begin
          e_done = 0; m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_busy", busy, e_busy);
      chk("cyc_done", done, e_done);
      chk("cyc_diff", diff, e_diff);
      chk("cyc_bout", bout, e_bout);
`ifdef SERIAL_SUB_OVF_EN
      chk("cyc_ovf", ovf, e_ovf);
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input logic [W-1:0] xd, input logic xb, input string nm);
    int cyc, nbusy;
    bit seen;
    @(negedge clk); a = ta; b = tb; bin = tbin; start = 1;
    @(negedge clk); start = 0; a = ~ta; b = ~tb; bin = ~tbin;
    cyc = 1; nbusy = 0; seen = 0;
    while (!seen && cyc <= 4 * W) begin
      if (busy) nbusy++;
      if (done) seen = 1;
      else begin
        @(negedge clk); cyc++;
      end
    end
    chk({nm, "_done_seen"}, seen, 1);
    chk({nm, "_latency"}, cyc, W + 1);
    chk({nm, "_busy_cycles"}, nbusy, W);
    chk({nm, "_diff"}, diff, xd);
    chk({nm, "_bout"}, bout, xb);
    chk({nm, "_model_diff"}, e_diff, xd);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, done, 0);
  endtask

  int nd, cyc, last;
  bit seen;

  initial begin
    rst_n = 0; start = 0; a = '0; b = '0; bin = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    check_en = 1;
    rst_n = 1;

    run_op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, "basic");
    run_op(8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, "under1");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "under2");
`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, "ovf1");
    chk("ovf1_ovf", ovf, 1);
    run_op(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, "ovf2");
    chk("ovf2_ovf", ovf, 0);
`endif

    // start held through RUN and DONE with changed operands
    @(negedge clk); a = 8'h0F; b = 8'h01; bin = 0; start = 1;
    @(negedge clk); a = 8'hFF; b = 8'hFF; bin = 1;
    seen = 0; cyc = 0;
    while (!seen && cyc < 4 * W) begin
      if (done) seen = 1;
      else begin
        @(negedge clk); cyc++;
      end
    end
    chk("ign_done_seen", seen, 1);
    chk("ign_diff", diff, 8'h0E);
    chk("ign_bout", bout, 0);
    @(negedge clk); start = 0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ign_no_second_done", nd, 0);
    chk("ign_diff_held", diff, 8'h0E);

    // reset during RUN
    @(negedge clk); a = 8'h11; b = 8'h22; bin = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", busy, 1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bout", bout, 0);
    rst_n = 1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_no_done", nd, 0);
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "after_rst");

    // back-to-back with start held, random operands every cycle
    @(negedge clk); start = 1;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    nd = 0; cyc = 0; last = 0;
    while (nd < 1000 && cyc < 12000) begin
      @(negedge clk); cyc++;
      if (done) begin
        nd++;
        if (nd > 1 && nd <= 6) chk("b2b_spacing", cyc - last, W + 2);
        last = cyc;
      end
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    end
    chk("sweep_count", nd, 1000);
    start = 0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
